evg_tx_framer: RTL



---
 rtl/evg_pkg.sv | 22 ++
 rtl/evg_dbuf_framer.sv | 96 +++++++++
 rtl/evg_tx_framer.sv | 81 ++++++++
 3 files changed

// File: rtl/evg_pkg.sv
// rtl/evg_pkg.sv - shared 8b10b control codes, framer state type and checksum helper
package evg_pkg;

  localparam logic [7:0] K28_5     = 8'hBC;
  localparam logic [7:0] K28_0     = 8'h1C;
  localparam logic [7:0] K28_1     = 8'h3C;
  localparam logic [7:0] NULL_CODE = 8'h00;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    STOP,
    CHK_HI,
    CHK_LO
  } frm_state_t;

  // Ones-complement style trailer: receiver adds payload sum and checksum to get 0xFFFF.
  function automatic logic [15:0] dbuf_chk(input logic [15:0] sum);
    return 16'hFFFF - sum;
  endfunction

endpackage

// File: rtl/evg_dbuf_framer.sv
// rtl/evg_dbuf_framer.sv - data-buffer frame FSM producing the byte-1 content of dbuf slots
module evg_dbuf_framer
  import evg_pkg::*;
#(
  parameter int DBUF_MAX = 255
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       phase,
  input  logic       tx_ready,
  input  logic       db_valid,
  input  logic [7:0] db_data,
  input  logic       db_last,
  output logic       db_ready,
  output logic [7:0] byte1,
  output logic       k1,
  output logic       err
);

  localparam logic [10:0] CNT_LAST = 11'(DBUF_MAX);

  frm_state_t  state, state_nxt;
  logic [15:0] sum, sum_nxt;
  logic [10:0] cnt, cnt_nxt;
  logic [15:0] chk;

  assign chk      = dbuf_chk(sum);
  assign db_ready = phase && tx_ready && (state == DATA);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      sum   <= 16'h0000;
      cnt   <= 11'd0;
    end else begin
      state <= state_nxt;
      sum   <= sum_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sum_nxt   = sum;
    cnt_nxt   = cnt;
    byte1     = NULL_CODE;
    k1        = 1'b0;
    err       = 1'b0;
    // Link loss aborts immediately, independent of slot phase.
    if (!tx_ready) begin
      state_nxt = IDLE;
      err       = (state != IDLE);
    end else if (phase) begin
      case (state)
        IDLE: begin
          if (db_valid) begin
            byte1     = K28_0;
            k1        = 1'b1;
            sum_nxt   = 16'h0000;
            cnt_nxt   = 11'd0;
            state_nxt = DATA;
          end
        end
        DATA: begin
          if (db_valid) begin
            byte1   = db_data;
            sum_nxt = sum + {8'h00, db_data};
            cnt_nxt = cnt + 11'd1;
            if (db_last || (cnt_nxt == CNT_LAST)) state_nxt = STOP;
          end else begin
            // Underrun: close the frame now; trailer covers bytes already sent.
            byte1     = K28_1;
            k1        = 1'b1;
            err       = 1'b1;
            state_nxt = CHK_HI;
          end
        end
        STOP: begin
          byte1     = K28_1;
          k1        = 1'b1;
          state_nxt = CHK_HI;
        end
        CHK_HI: begin
          byte1     = chk[15:8];
          state_nxt = CHK_LO;
        end
        CHK_LO: begin
          byte1     = chk[7:0];
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: rtl/evg_tx_framer.sv
// rtl/evg_tx_framer.sv - EVG transmit framer: event/comma byte 0, dbus/dbuf byte 1, registered GTY words
module evg_tx_framer
  import evg_pkg::*;
#(
  parameter int COMMA_MAX = 64,
  parameter int DBUF_MAX  = 255
) (
  input  logic        txusrclk2_in,
  input  logic        resetn_in,
  input  logic        tx_ready_in,
  input  logic        ev_valid_in,
  output logic        ev_ready_out,
  input  logic [7:0]  ev_code_in,
  input  logic [7:0]  dbus_in,
  input  logic        db_valid_in,
  output logic        db_ready_out,
  input  logic [7:0]  db_data_in,
  input  logic        db_last_in,
  output logic [15:0] txdata_out,
  output logic [7:0]  txctrl2_out,
  output logic        db_err_out
);

  localparam logic [7:0] COMMA_LAST = 8'(COMMA_MAX - 1);

  logic       phase;
  logic [7:0] comma_cnt;
  logic       comma_due;
  logic       ev_accept;
  logic [7:0] byte0, byte1, fr_byte;
  logic       k0, k1, fr_k, fr_err;

  assign comma_due    = (comma_cnt == COMMA_LAST) || !tx_ready_in;
  assign ev_ready_out = resetn_in && !comma_due;
  assign ev_accept    = ev_valid_in && ev_ready_out;

  evg_dbuf_framer #(
    .DBUF_MAX(DBUF_MAX)
  ) u_dbuf (
    .clk     (txusrclk2_in),
    .resetn  (resetn_in),
    .phase   (phase),
    .tx_ready(tx_ready_in),
    .db_valid(db_valid_in),
    .db_data (db_data_in),
    .db_last (db_last_in),
    .db_ready(db_ready_out),
    .byte1   (fr_byte),
    .k1      (fr_k),
    .err     (fr_err)
  );

  always_comb begin
    byte0 = K28_5;
    k0    = 1'b1;
    if (ev_accept) begin
      byte0 = ev_code_in;
      k0    = 1'b0;
    end
    byte1 = phase ? fr_byte : dbus_in;
    k1    = phase ? fr_k : 1'b0;
  end

  always_ff @(posedge txusrclk2_in) begin
    if (!resetn_in) begin
      phase       <= 1'b0;
      comma_cnt   <= 8'd0;
      txdata_out  <= {NULL_CODE, K28_5};
      txctrl2_out <= 8'h01;
      db_err_out  <= 1'b0;
    end else begin
      phase       <= ~phase;
      // Any comma on byte 0, forced or idle, restarts the spacing count.
      comma_cnt   <= ev_accept ? comma_cnt + 8'd1 : 8'd0;
      txdata_out  <= {byte1, byte0};
      txctrl2_out <= {6'b000000, k1, k0};
      db_err_out  <= fr_err;
    end
  end

endmodule
